// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: hunts SYNC_BYTE, buffers a length/payload/checksum frame, streams it out.
// Define UART_FRAME_TIMEOUT_EN to abort frames whose inter-byte gap reaches TIMEOUT_CLKS.
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 870
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [7:0]  o_Data,
  output logic        o_Last,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code,
  output logic [15:0] o_Frame_Count,
  output logic [7:0]  o_Drop_Count
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_L = 8'(MAX_LEN);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    HUNT, LEN, PAYLOAD, CHK, DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  wr_q, wr_d;
  logic [7:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] frames_q, frames_d;
  logic [7:0]  drops_q, drops_d;
  logic [7:0]  buf_q [MAX_LEN];
  logic        buf_we;
  logic [7:0]  chk_sum;
  logic        last_beat;
  logic        xfer;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [15:0] tmr_q, tmr_d;
`else
  // keeps the timeout parameter referenced when the timer is compiled out
  logic unused_timeout;
  assign unused_timeout = ^TO_MAX;
`endif

  assign chk_sum   = sum_q + i_Rx_Byte;
  assign last_beat = (rd_q == len_q - 8'd1);
  assign xfer      = (state_q == DRAIN) && i_Ready;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= HUNT;
      len_q    <= '0;
      sum_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      frames_q <= '0;
      drops_q  <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      code_q   <= code_d;
      frames_q <= frames_d;
      drops_q  <= drops_d;
`ifdef UART_FRAME_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  // payload storage needs no reset; only bytes below len_q are ever read
  always_ff @(posedge i_Clock) begin
    if (buf_we) buf_q[wr_q[IW-1:0]] <= i_Rx_Byte;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    sum_d    = sum_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    err_d    = 1'b0;
    code_d   = code_q;
    frames_d = frames_q;
    drops_d  = drops_q;
    buf_we   = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
    tmr_d    = '0;
`endif
    unique case (state_q)
      HUNT: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_L) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = HUNT;
          end else begin
            len_d   = i_Rx_Byte;
            sum_d   = i_Rx_Byte;
            wr_d    = '0;
            rd_d    = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we = 1'b1;
          sum_d  = chk_sum;
          wr_d   = wr_q + 8'd1;
          if (wr_q == len_q - 8'd1) state_d = CHK;
        end
      end
      CHK: begin
        if (i_Rx_DV) begin
          if (chk_sum == 8'd0) begin
            state_d = DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = HUNT;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          rd_d = rd_q + 8'd1;
          if (last_beat) begin
            frames_d = frames_q + 16'd1;
            state_d  = HUNT;
          end
        end
        // the receiver cannot be stalled, so a byte arriving now is lost
        if (i_Rx_DV) begin
          err_d  = 1'b1;
          code_d = 2'd0;
          if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
        end
      end
      default: state_d = HUNT;
    endcase
`ifdef UART_FRAME_TIMEOUT_EN
    if (state_q inside {LEN, PAYLOAD, CHK} && !i_Rx_DV) begin
      tmr_d = tmr_q + 16'd1;
      if (tmr_d == TO_MAX) begin
        err_d   = 1'b1;
        code_d  = 2'd3;
        state_d = HUNT;
      end
    end
`endif
  end

  always_comb begin
    o_Valid       = (state_q == DRAIN);
    o_Data        = o_Valid ? buf_q[rd_q[IW-1:0]] : 8'h00;
    o_Last        = o_Valid && last_beat;
    o_Err         = err_q;
    o_Err_Code    = code_q;
    o_Frame_Count = frames_q;
    o_Drop_Count  = drops_q;
  end

endmodule
